byte_sar_search: RTL
====================

BYTE_SAR_SEARCH -- requirements
Module: byte_sar_search

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the key/guess width in bits.
REQ-002 SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have input rst, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have input start, 1 bit: begin a search; sampled only in IDLE.
REQ-005 SHALL have input key, WIDTH bits: search target; captured on an accepted start.
REQ-006 SHALL have output dina, WIDTH bits: current guess, registered, driven to the external byte comparator.
REQ-007 SHALL have output dinb, WIDTH bits: latched key, registered, driven to the comparator.
REQ-008 SHALL have inputs gt, eq, le, 1 bit each, from the comparator: gt when dina>dinb, eq when dina==dinb, le when dina<dinb.
REQ-009 SHALL have output busy, 1 bit: high while in state CMP.
REQ-010 SHALL have output done, 1 bit: one-cycle pulse on successful completion.
REQ-011 SHALL have output err, 1 bit: one-cycle pulse on comparator fault.
REQ-012 SHALL have output result, WIDTH bits: matched value; held until the next accepted start.

Function
REQ-013 SHALL implement states IDLE, CMP and END; the comparator is combinational, so flags SHALL be sampled in the same cycle the guess is presented.
REQ-014 In IDLE with start=1, SHALL latch key into dinb, set lo=0 and hi=2^WIDTH-1, drive dina=(lo+hi)>>1 (127 for WIDTH=8), and enter CMP.
REQ-015 The midpoint SHALL be computed with WIDTH+1-bit arithmetic; no truncation of lo+hi.
REQ-016 In CMP on eq: SHALL load result=dina, pulse done in the next cycle (END) and return to IDLE.
REQ-017 In CMP on gt: SHALL set hi=dina-1 and present the new midpoint next cycle; on le, SHALL set lo=dina+1 likewise.
REQ-018 SHALL treat as a fault: flags not exactly one-hot (including X/all-zero), gt with dina==0, le with dina==2^WIDTH-1, or lo>hi after an update; the response SHALL be to pulse err in END and return to IDLE with result unchanged.
REQ-019 A valid search SHALL complete in at most WIDTH+1 CMP cycles (9 for WIDTH=8).
REQ-020 start asserted while busy or in END SHALL be ignored, with no effect on the search in progress.
REQ-021 done and err SHALL never be asserted together; busy SHALL be low whenever done or err is high.
REQ-022 dina and dinb SHALL remain stable except on a CMP-cycle update or an accepted start.

Reset
REQ-023 On rst=1 at a clock edge, SHALL enter IDLE with dina=0, dinb=0, result=0, busy=0, done=0, err=0, lo=0, hi=all-ones.
REQ-024 Reset asserted mid-search SHALL abandon the search with no done or err pulse.
REQ-025 rst SHALL take priority over start.

Configuration
REQ-026 With SAR_STEPCNT_EN defined, SHALL add output steps, 4 bits: the number of CMP cycles in the last search, updated with done/err, reset to 0. Without the macro, the port and its counter SHALL be absent and behaviour otherwise identical.

Structure
REQ-027 State encodings (IDLE=0, CMP=1, END=2) and the WIDTH default SHALL reside in shared package byte_sar_pkg.
REQ-028 The flag-validity and boundary fault check SHALL be sub-module sar_flag_chk (combinational: flags and dina in, fault out).

Verification
REQ-029 key=127, start: dina=127 in the first CMP cycle, eq -> done next cycle, result=127, steps=1.
REQ-030 key=0: guesses 127,63,31,15,7,3,1,0 -> done, result=0, steps=8.
REQ-031 key=255: guesses 127,191,223,239,247,251,253,254,255 -> done, result=255, steps=9.
REQ-032 Comparator replaced by stub driving gt=eq=le=0: err pulses after the first CMP cycle, result retains its prior value, done stays 0.
REQ-033 rst pulsed during the 3rd CMP cycle of key=0, and start pulsed during busy: the search aborts to IDLE with all outputs at reset values and no done/err; the extra start is ignored.

Source files
------------

// File: rtl/byte_sar_pkg.sv
// Shared definitions for the byte successive-approximation search block.
// State encodings, default key width and the step-counter width.
package byte_sar_pkg;

  localparam int SAR_WIDTH = 8;
  localparam int STEP_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    END  = 2'd2
  } sar_state_t;

endpackage

// File: rtl/sar_flag_chk.sv
// Comparator flag sanity check: flags must be one-hot and must not point
// outside the representable range of the current guess.
module sar_flag_chk
  import byte_sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             gt,
  input  logic             eq,
  input  logic             le,
  input  logic [WIDTH-1:0] dina,
  output logic             fault
);

  always_comb begin
    fault = 1'b1;
    // NOTE: an X or Z flag matches no item and falls to the default, so unknown flags read as a fault.
    case ({gt, eq, le})
      3'b100:  fault = (dina == '0);
      3'b010:  fault = 1'b0;
      3'b001:  fault = (dina == '1);
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/byte_sar_search.sv
// Binary search for a key using an external combinational comparator.
// Define SAR_STEPCNT_EN to add the 'steps' output (CMP cycles of last search).
module byte_sar_search
  import byte_sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] dina,
  output logic [WIDTH-1:0] dinb,
  input  logic             gt,
  input  logic             eq,
  input  logic             le,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
`ifdef SAR_STEPCNT_EN
  ,
  output logic [STEP_W-1:0] steps
`endif
);

  sar_state_t       state, state_n;
  logic [WIDTH-1:0] lo, hi, lo_n, hi_n;
  logic [WIDTH-1:0] nxt_lo, nxt_hi;
  logic [WIDTH-1:0] dina_n, dinb_n, result_n;
  logic             done_n, err_n;
  logic             flag_fault;

  // Sum is one bit wider so lo+hi never wraps before the halving.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  sar_flag_chk #(.WIDTH(WIDTH)) u_flag_chk (
    .gt   (gt),
    .eq   (eq),
    .le   (le),
    .dina (dina),
    .fault(flag_fault)
  );

  assign nxt_lo = le ? dina + 1'b1 : lo;
  assign nxt_hi = gt ? dina - 1'b1 : hi;
  assign busy   = (state == CMP);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    dina_n   = dina;
    dinb_n   = dinb;
    result_n = result;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          dinb_n  = key;
          lo_n    = '0;
          hi_n    = '1;
          dina_n  = midpoint('0, '1);
          state_n = CMP;
        end
      end
      CMP: begin
        state_n = END;
        if (flag_fault) begin
          err_n = 1'b1;
        end else if (eq) begin
          result_n = dina;
          done_n   = 1'b1;
        end else if (nxt_lo > nxt_hi) begin
          err_n = 1'b1;
        end else begin
          lo_n    = nxt_lo;
          hi_n    = nxt_hi;
          dina_n  = midpoint(nxt_lo, nxt_hi);
          state_n = CMP;
        end
      end
      END:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '1;
      dina   <= '0;
      dinb   <= '0;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      dina   <= dina_n;
      dinb   <= dinb_n;
      result <= result_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

`ifdef SAR_STEPCNT_EN
  logic [STEP_W-1:0] cnt;

  // steps is published on the same edge that raises done or err.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      steps <= '0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
    end else if (state == CMP) begin
      if (state_n == END) steps <= cnt + 1'b1;
      else                cnt   <= cnt + 1'b1;
    end
  end
`endif

endmodule
